// File: rtl/aes_inv_key_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_inv_key_sched_if
//  Description : Bus bundle between the key register / round-engine side and
//                the inverse AES-128 key scheduler.
//                  key_load  : 1-cycle strobe, capture key_in, start expansion
//                  key_in    : 128-bit cipher key (byte 0 in [127:120])
//                  rk_req    : step to the previous round key
//                  busy      : forward expansion in progress
//                  key_ready : round keys available
//                  rk_out    : current round key
//                  rk_round  : index of rk_out (10..0)
//                master = requester side, slave = scheduler side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes_inv_key_sched_if #(
    parameter int RK_W = 128
);
    logic            key_load;
    logic [RK_W-1:0] key_in;
    logic            rk_req;
    logic            busy;
    logic            key_ready;
    logic [RK_W-1:0] rk_out;
    logic [3:0]      rk_round;

    modport master (
        output key_load,
        output key_in,
        output rk_req,
        input  busy,
        input  key_ready,
        input  rk_out,
        input  rk_round
    );

    modport slave (
        input  key_load,
        input  key_in,
        input  rk_req,
        output busy,
        output key_ready,
        output rk_out,
        output rk_round
    );
endinterface
`default_nettype wire

// File: rtl/aes_inv_key_sched.sv
`default_nettype none
// ============================================================================
//  Module      : aes_inv_key_sched
//  Description : Sequential AES-128 round-key generator for decryption.
//                On key_load the forward schedule runs one round per cycle
//                and round key 10 is saved; afterwards each rk_req steps one
//                round backwards (10 -> 0), wrapping from 0 back to the saved
//                round key 10 so consecutive blocks need no re-expansion.
//                One shared 4-S-box SubWord serves both directions.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                ks_io  - slave side of aes_inv_key_sched_if (key_load,
//                         key_in, rk_req in; busy, key_ready, rk_out,
//                         rk_round out)
//  Parameters  : NR   - number of rounds, only 10 is supported
//                RK_W - round-key width, fixed at 128
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_key_sched #(
    parameter int NR   = 10,
    parameter int RK_W = 128
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    aes_inv_key_sched_if.slave    ks_io
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXPAND = 2'd1;
    localparam logic [1:0] S_READY  = 2'd2;

    localparam logic [3:0] C_LAST_RND = 4'(NR);

    // AES S-box, element 0 is the most significant byte of the literal.
    localparam logic [0:255][7:0] C_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    logic [1:0]      state_q, state_d;
    logic [RK_W-1:0] cur_q,   cur_d;
    logic [RK_W-1:0] k10_q,   k10_d;
    logic [3:0]      rnd_q,   rnd_d;

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_inv_w1, w_inv_w2, w_inv_w3, w_inv_w0;
    logic [31:0] w_fwd_w0, w_fwd_w1, w_fwd_w2, w_fwd_w3;
    logic [31:0] w_sub_src, w_rot, w_sub, w_t;
    logic [3:0]  w_rcon_idx;
    logic        w_expanding;

    assign w_w0 = cur_q[127:96];
    assign w_w1 = cur_q[95:64];
    assign w_w2 = cur_q[63:32];
    assign w_w3 = cur_q[31:0];

    assign w_expanding = (state_q == S_EXPAND);

    // Undo the XOR chain first; the recovered previous w3 then feeds the
    // same SubWord/Rcon path the forward step uses on the current w3.
    assign w_inv_w3 = w_w3 ^ w_w2;
    assign w_inv_w2 = w_w2 ^ w_w1;
    assign w_inv_w1 = w_w1 ^ w_w0;

    // Forward uses Rcon of the round being produced, inverse uses Rcon of
    // the round being undone.
    assign w_sub_src  = w_expanding ? w_w3 : w_inv_w3;
    assign w_rcon_idx = w_expanding ? (rnd_q + 4'd1) : rnd_q;
    assign w_rot      = {w_sub_src[23:0], w_sub_src[31:24]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        assign w_sub[8*gi +: 8] = C_SBOX[w_rot[8*gi +: 8]];
    end

    assign w_t = w_sub ^ {rcon(w_rcon_idx), 24'h000000};

    assign w_fwd_w0 = w_w0 ^ w_t;
    assign w_fwd_w1 = w_w1 ^ w_fwd_w0;
    assign w_fwd_w2 = w_w2 ^ w_fwd_w1;
    assign w_fwd_w3 = w_w3 ^ w_fwd_w2;

    assign w_inv_w0 = w_w0 ^ w_t;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        k10_d   = k10_q;
        rnd_d   = rnd_q;
        // key_load restarts from any state and takes priority over rk_req.
        if (ks_io.key_load) begin
            cur_d   = ks_io.key_in;
            rnd_d   = 4'd0;
            state_d = S_EXPAND;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_EXPAND: begin
                    cur_d = {w_fwd_w0, w_fwd_w1, w_fwd_w2, w_fwd_w3};
                    rnd_d = rnd_q + 4'd1;
                    if (rnd_q == C_LAST_RND - 4'd1) begin
                        k10_d   = {w_fwd_w0, w_fwd_w1, w_fwd_w2, w_fwd_w3};
                        state_d = S_READY;
                    end
                end
                S_READY: begin
                    if (ks_io.rk_req) begin
                        if (rnd_q != 4'd0) begin
                            cur_d = {w_inv_w0, w_inv_w1, w_inv_w2, w_inv_w3};
                            rnd_d = rnd_q - 4'd1;
                        end else begin
                            cur_d = k10_q;
                            rnd_d = C_LAST_RND;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            k10_q   <= '0;
            rnd_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            k10_q   <= k10_d;
            rnd_q   <= rnd_d;
        end
    end

    // cur_q/rnd_q are cleared by reset, so the outputs read zero in IDLE
    // after reset without extra gating.
    assign ks_io.busy      = w_expanding;
    assign ks_io.key_ready = (state_q == S_READY);
    assign ks_io.rk_out    = cur_q;
    assign ks_io.rk_round  = rnd_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_key_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_inv_key_sched
//  Description : Directed self-checking bench for aes_inv_key_sched using
//                FIPS-197 key expansion vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_inv_key_sched;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   n_busy;

    aes_inv_key_sched_if #(.RK_W(128)) ks_if ();

    aes_inv_key_sched #(.NR(10), .RK_W(128)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ks_io (ks_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] C_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C_ZK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    // FIPS-197 Appendix A.1 round keys 0..10
    logic [127:0] rk_tab [0:10];
    initial begin
        rk_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the capture edge.
    task automatic load_key(input logic [127:0] k);
        ks_if.key_in   = k;
        ks_if.key_load = 1'b1;
        @(negedge clk);
        ks_if.key_load = 1'b0;
    endtask

    // Counts negedges with busy high, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (ks_if.busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst_n          = 1'b0;
        ks_if.key_load = 1'b0;
        ks_if.key_in   = '0;
        ks_if.rk_req   = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_busy",  128'(ks_if.busy),      128'd0);
        chk("rst_ready", 128'(ks_if.key_ready), 128'd0);
        chk("rst_rkout", ks_if.rk_out,          128'd0);
        chk("rst_round", 128'(ks_if.rk_round),  128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: forward expansion
        load_key(C_KEY);
        wait_done(n_busy);
        chk("t1_busy_cycles", 128'(n_busy),            128'd10);
        chk("t1_ready",       128'(ks_if.key_ready),   128'd1);
        chk("t1_round",       128'(ks_if.rk_round),    128'd10);
        chk("t1_rk10",        ks_if.rk_out,            rk_tab[10]);

        // T2: single step back
        ks_if.rk_req = 1'b1;
        @(negedge clk);
        ks_if.rk_req = 1'b0;
        chk("t2_round", 128'(ks_if.rk_round), 128'd9);
        chk("t2_rk9",   ks_if.rk_out,         rk_tab[9]);
        @(negedge clk);
        chk("t2_hold_round", 128'(ks_if.rk_round), 128'd9);

        // T3: reload, then hold rk_req: 10 -> 0 -> wrap to 10
        load_key(C_KEY);
        wait_done(n_busy);
        chk("t3_busy_cycles", 128'(n_busy), 128'd10);
        ks_if.rk_req = 1'b1;
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            chk($sformatf("t3_round%0d", i), 128'(ks_if.rk_round), 128'(i));
            chk($sformatf("t3_rk%0d", i),    ks_if.rk_out,         rk_tab[i]);
        end
        @(negedge clk);
        ks_if.rk_req = 1'b0;
        chk("t3_wrap_round", 128'(ks_if.rk_round), 128'd10);
        chk("t3_wrap_rk",    ks_if.rk_out,         rk_tab[10]);
        chk("t3_wrap_ready", 128'(ks_if.key_ready), 128'd1);

        // T4: zero-key load in cycle 5 of expansion
        load_key(C_KEY);
        repeat (4) @(negedge clk);
        chk("t4_busy_c5", 128'(ks_if.busy), 128'd1);
        load_key(128'd0);
        chk("t4_restart_round", 128'(ks_if.rk_round), 128'd0);
        chk("t4_restart_rk",    ks_if.rk_out,         128'd0);
        wait_done(n_busy);
        chk("t4_busy_cycles", 128'(n_busy),          128'd10);
        chk("t4_ready",       128'(ks_if.key_ready), 128'd1);
        chk("t4_rk10",        ks_if.rk_out,          C_ZK10);

        // T5: key_load and rk_req together in READY
        ks_if.key_in   = C_KEY;
        ks_if.key_load = 1'b1;
        ks_if.rk_req   = 1'b1;
        @(negedge clk);
        ks_if.key_load = 1'b0;
        ks_if.rk_req   = 1'b0;
        chk("t5_busy",  128'(ks_if.busy),      128'd1);
        chk("t5_ready", 128'(ks_if.key_ready), 128'd0);
        chk("t5_round", 128'(ks_if.rk_round),  128'd0);
        chk("t5_rk",    ks_if.rk_out,          C_KEY);
        wait_done(n_busy);
        chk("t5_busy_cycles", 128'(n_busy), 128'd10);
        chk("t5_rk10",        ks_if.rk_out, rk_tab[10]);

        // T6: asynchronous reset mid-expansion
        load_key(C_KEY);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy",  128'(ks_if.busy),      128'd0);
        chk("t6_ready", 128'(ks_if.key_ready), 128'd0);
        chk("t6_rk",    ks_if.rk_out,          128'd0);
        chk("t6_round", 128'(ks_if.rk_round),  128'd0);
        @(negedge clk);
        rst_n        = 1'b1;
        ks_if.rk_req = 1'b1;
        repeat (3) @(negedge clk);
        ks_if.rk_req = 1'b0;
        chk("t6_req_ready", 128'(ks_if.key_ready), 128'd0);
        chk("t6_req_busy",  128'(ks_if.busy),      128'd0);
        chk("t6_req_round", 128'(ks_if.rk_round),  128'd0);
        chk("t6_req_rk",    ks_if.rk_out,          128'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
